logic_op_identifier: RTL and testbench
======================================

Name: logic_op_identifier

Overview:
- Inverse of the 8-function two-input logic unit used in Guia 7: given a unit whose 3-bit operation select is unknown, it identifies the select code.
- It drives all four input combinations onto the unit's a/b inputs and samples the unit's single-bit output for each.
- It builds the 4-bit truth table and decodes it back to the operation code.
- Sits beside the logic unit as a self-test/identification engine, started by a one-cycle request and finishing with a done pulse.

Parameters:
- SETTLE_CYCLES, default 1: extra cycles to wait after driving a probe vector before sampling probe_out. Legal values are 0..15.

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to begin identification; sampled only in IDLE
- probe_a  output  1  drives the logic unit's a input (registered)
- probe_b  output  1  drives the logic unit's b input (registered)
- probe_out  input  1  logic unit result; treated as combinational from probe_a/probe_b
- busy  output  1  high while in WAIT or DONE
- done  output  1  one-cycle pulse; results are valid from this cycle on
- truth_table  output  4  captured result; bit i = probe_out for {a,b} = i
- op_code  output  3  decoded select code
- valid  output  1  truth_table matched one of the 8 operations

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; index 0; settle counter 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On start=1 at edge k: state becomes WAIT, index=0, {probe_a,probe_b}=2'b00, counter=0.
  - truth_table/op_code/valid keep their previous values.
- WAIT:
  - Each edge: if counter < SETTLE_CYCLES, counter++.
  - Otherwise, sample: truth_table[index] <= probe_out and counter <= 0.
  - If index < 3 at the sample: index++ and {probe_a,probe_b} <= index+1.
  - If index == 3 at the sample: go to DONE; on the same edge register op_code/valid from the completed table (including the bit just sampled); probes return to 00.
- Timing per vector: vector i is driven at edge k+i*(S+1) and sampled at edge k+(i+1)*(S+1), where S = SETTLE_CYCLES.
- DONE: done=1 for exactly one cycle, starting after edge k+4*(S+1); next edge goes to IDLE.
- Latency: start to done = 4*(S+1) edges. With S=1, done is high after edge k+8.
- Decode of truth_table bits [3:0], each mapping to op_code with valid=1:
  - 0011 -> 000 (NOT A)
  - 0101 -> 001 (NOT B)
  - 1000 -> 010 (AND)
  - 0111 -> 011 (NAND)
  - 0110 -> 100 (XOR)
  - 1001 -> 101 (XNOR)
  - 1110 -> 110 (OR)
  - 0001 -> 111 (NOR)
  - Any other pattern -> op_code=000, valid=0.
- probe_out X/Z: captured as-is in truth_table; the decode yields valid=0.
- start while busy (WAIT or DONE): ignored, with no restart and no queueing.
- start in the cycle after done: accepted normally.
- Results are held until the next run's DONE edge; they are not cleared at start.
- reset mid-run: immediate return to the reset values; no done pulse; the partial table is discarded.

Decomposition:
- Shared package logic_op_pkg holds:
  - op code constants OP_NOTA..OP_NOR (3'b000..3'b111);
  - the 8 truth-table constants TT_NOTA..TT_NOR;
  - the state enum (IDLE, WAIT, DONE).
- One natural sub-module: logic_op_decoder, purely combinational, 4-bit truth_table -> {valid, op_code}. It is reusable, and the same package constants serve the forward logic unit.

Test Plan:
- Reset state: reset asserted mid-cycle, then released -> all outputs 0, busy=0; start while reset=1 is ignored.
- Full sweep: S=1, logic unit select fixed at 3'b100 (XOR), start pulsed at edge k -> probes step 00,01,10,11 at k, k+2, k+4, k+6; done=1 after edge k+8; truth_table=0110, op_code=100, valid=1.
- All eight selects: loop over select 000..111 with S=0 -> done after 4 edges each; op_code equals select and valid=1 every time; NOT B gives table 0101.
- Invalid pattern: probe_out tied to 1 -> truth_table=1111, valid=0, op_code=000.
- Start while busy and back-to-back runs: start pulsed again during WAIT -> no effect, and done occurs once at the original time; start held high through DONE -> a second run begins in the cycle after done (first IDLE cycle), probes at 00.
- Reset mid-run: reset asserted after the 2nd sample -> immediate zeros, no done; a subsequent clean run (select 110) gives 1110/110/valid=1.

Source files
------------

// File: rtl/logic_op_pkg.sv
// Shared definitions for the two-input logic unit family: operation codes,
// the truth table each operation produces, and the identifier FSM states.
// Truth table bit i holds the unit output for {a,b} = i.
package logic_op_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  localparam logic [3:0] TT_NOTA = 4'b0011;
  localparam logic [3:0] TT_NOTB = 4'b0101;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  // Forward model of the logic unit, usable by the unit itself or by any
  // block that needs to predict its output for a given select.
  function automatic logic logic_unit_eval(input logic [2:0] op,
                                           input logic a,
                                           input logic b);
    logic r;
    case (op)
      OP_NOTA: r = ~a;
      OP_NOTB: r = ~b;
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_identifier_if.sv
// Connection bundle between the identifier and its environment: the request /
// result handshake plus the probe lines that drive and observe the logic unit.
interface logic_op_identifier_if;

  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] truth_table;
  logic [2:0] op_code;
  logic       valid;
  logic       probe_a;
  logic       probe_b;
  logic       probe_out;

  // Environment side: requests runs, returns the unit output, reads results.
  modport master (
    output start,
    output probe_out,
    input  busy,
    input  done,
    input  truth_table,
    input  op_code,
    input  valid,
    input  probe_a,
    input  probe_b
  );

  // Identifier side.
  modport slave (
    input  start,
    input  probe_out,
    output busy,
    output done,
    output truth_table,
    output op_code,
    output valid,
    output probe_a,
    output probe_b
  );

endinterface

// File: rtl/logic_op_decoder.sv
// Maps a 4-bit truth table back to the select code of the operation that
// produces it. Patterns that belong to no operation (including unknown bits)
// give valid=0 and op_code=000.
module logic_op_decoder
  import logic_op_pkg::*;
(
  input  logic [3:0] truth_table,
  output logic [2:0] op_code,
  output logic       valid
);

  // Exact-match lookup; an X/Z bit matches no constant and falls to default.
  always_comb begin
    op_code = OP_NOTA;
    valid   = 1'b0;
    case (truth_table)
      TT_NOTA: begin op_code = OP_NOTA; valid = 1'b1; end
      TT_NOTB: begin op_code = OP_NOTB; valid = 1'b1; end
      TT_AND:  begin op_code = OP_AND;  valid = 1'b1; end
      TT_NAND: begin op_code = OP_NAND; valid = 1'b1; end
      TT_XOR:  begin op_code = OP_XOR;  valid = 1'b1; end
      TT_XNOR: begin op_code = OP_XNOR; valid = 1'b1; end
      TT_OR:   begin op_code = OP_OR;   valid = 1'b1; end
      TT_NOR:  begin op_code = OP_NOR;  valid = 1'b1; end
      default: begin op_code = OP_NOTA; valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/logic_op_identifier.sv
// Identification engine for the two-input logic unit. On a start request it
// walks {a,b} through 00,01,10,11, waits SETTLE_CYCLES after each vector,
// samples the unit output, and decodes the collected truth table into the
// unit's select code. Published results change only on the DONE edge.
module logic_op_identifier
  import logic_op_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  logic_op_identifier_if.slave bus
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE_CYCLES);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0] state_r;
  logic [1:0] index_r;
  logic [3:0] cnt_r;
  logic [2:0] tt_work_r;
  logic       probe_a_r;
  logic       probe_b_r;
  logic       busy_r;
  logic       done_r;
  logic [3:0] truth_table_r;
  logic [2:0] op_code_r;
  logic       valid_r;

  logic       sample_s;
  logic       last_s;
  logic [1:0] index_next_s;
  logic [3:0] tt_full_s;
  logic [2:0] dec_op_s;
  logic       dec_valid_s;

  // Sample strobe, final-vector flag and the complete table including the
  // bit currently present on probe_out.
  always_comb begin
    sample_s     = 1'b0;
    last_s       = 1'b0;
    index_next_s = 2'(index_r + 2'd1);
    tt_full_s    = {bus.probe_out, tt_work_r};
    if (state_r == ST_WAIT) begin
      sample_s = (cnt_r == SETTLE_L);
      last_s   = (index_r == 2'd3);
    end else begin
      sample_s = 1'b0;
      last_s   = 1'b0;
    end
  end

  logic_op_decoder u_decoder (
    .truth_table (tt_full_s),
    .op_code     (dec_op_s),
    .valid       (dec_valid_s)
  );

  // Sequencer: settle counting, probe stepping and the done/busy flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      index_r   <= 2'd0;
      cnt_r     <= 4'd0;
      probe_a_r <= 1'b0;
      probe_b_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r   <= ST_WAIT;
            index_r   <= 2'd0;
            cnt_r     <= 4'd0;
            probe_a_r <= 1'b0;
            probe_b_r <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!sample_s) begin
            cnt_r <= 4'(cnt_r + 4'd1);
          end else begin
            cnt_r <= 4'd0;
            if (last_s) begin
              state_r   <= ST_DONE;
              probe_a_r <= 1'b0;
              probe_b_r <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              index_r   <= index_next_s;
              probe_a_r <= index_next_s[1];
              probe_b_r <= index_next_s[0];
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          index_r <= 2'd0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          index_r   <= 2'd0;
          cnt_r     <= 4'd0;
          probe_a_r <= 1'b0;
          probe_b_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  // Working table: collects the first three samples of the current run so a
  // partial run never disturbs the published result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tt_work_r <= 3'b000;
    end else if (sample_s) begin
      case (index_r)
        2'd0:    tt_work_r[0] <= bus.probe_out;
        2'd1:    tt_work_r[1] <= bus.probe_out;
        2'd2:    tt_work_r[2] <= bus.probe_out;
        default: tt_work_r    <= tt_work_r;
      endcase
    end else begin
      tt_work_r <= tt_work_r;
    end
  end

  // Published result: updated only on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      truth_table_r <= 4'b0000;
      op_code_r     <= 3'b000;
      valid_r       <= 1'b0;
    end else if (sample_s && last_s) begin
      truth_table_r <= tt_full_s;
      op_code_r     <= dec_op_s;
      valid_r       <= dec_valid_s;
    end else begin
      truth_table_r <= truth_table_r;
      op_code_r     <= op_code_r;
      valid_r       <= valid_r;
    end
  end

  assign bus.probe_a     = probe_a_r;
  assign bus.probe_b     = probe_b_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.truth_table = truth_table_r;
  assign bus.op_code     = op_code_r;
  assign bus.valid       = valid_r;

endmodule

// File: tb/tb_logic_op_identifier.sv
// Directed bench for logic_op_identifier: one instance with one settle cycle
// and one with none, each probing a behavioural logic unit.
module tb_logic_op_identifier;

  logic       clk;
  logic       reset;
  logic [2:0] sel1, sel0;
  logic       tie1, tie0;
  int         vectors;
  int         miscompares;

  logic_op_identifier_if if1 ();
  logic_op_identifier_if if0 ();

  logic_op_identifier #(.SETTLE_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  logic_op_identifier #(.SETTLE_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  // Behavioural logic unit, written independently from the design files.
  function automatic logic lu(input logic [2:0] s, input logic a, input logic b);
    case (s)
      3'd0:    return !a;
      3'd1:    return !b;
      3'd2:    return a && b;
      3'd3:    return !(a && b);
      3'd4:    return a != b;
      3'd5:    return a == b;
      3'd6:    return a || b;
      default: return !(a || b);
    endcase
  endfunction

  assign if1.probe_out = tie1 ? 1'b1 : lu(sel1, if1.probe_a, if1.probe_b);
  assign if0.probe_out = tie0 ? 1'b1 : lu(sel0, if0.probe_a, if0.probe_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [3:0] exp_tt [8];

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_tt = '{4'b0011, 4'b0101, 4'b1000, 4'b0111,
               4'b0110, 4'b1001, 4'b1110, 4'b0001};
    reset = 1'b0;
    if1.start = 1'b0;
    if0.start = 1'b0;
    sel1 = 3'd0; sel0 = 3'd0;
    tie1 = 1'b0; tie0 = 1'b0;

    // Reset asserted mid-cycle, start held high while in reset
    #2;
    reset = 1'b1;
    if1.start = 1'b1;
    if0.start = 1'b1;
    stepn(2);
    chk("rst_busy1", 4'(if1.busy), 4'd0);
    chk("rst_busy0", 4'(if0.busy), 4'd0);
    chk("rst_probes1", 4'({if1.probe_a, if1.probe_b}), 4'd0);
    chk("rst_tt1", if1.truth_table, 4'd0);
    chk("rst_op1", 4'(if1.op_code), 4'd0);
    chk("rst_valid1", 4'(if1.valid), 4'd0);
    chk("rst_done1", 4'(if1.done), 4'd0);
    if1.start = 1'b0;
    if0.start = 1'b0;
    reset = 1'b0;
    step();
    chk("post_rst_busy1", 4'(if1.busy), 4'd0);
    chk("post_rst_done0", 4'(if0.done), 4'd0);

    // Full sweep, S=1, XOR
    sel1 = 3'b100;
    if1.start = 1'b1;
    step();                                      // edge k
    if1.start = 1'b0;
    chk("xor_busy_k", 4'(if1.busy), 4'd1);
    chk("xor_probe_k", 4'({if1.probe_a, if1.probe_b}), 4'b0000);
    step();
    chk("xor_probe_k1", 4'({if1.probe_a, if1.probe_b}), 4'b0000);
    step();
    chk("xor_probe_k2", 4'({if1.probe_a, if1.probe_b}), 4'b0001);
    stepn(2);
    chk("xor_probe_k4", 4'({if1.probe_a, if1.probe_b}), 4'b0010);
    stepn(2);
    chk("xor_probe_k6", 4'({if1.probe_a, if1.probe_b}), 4'b0011);
    chk("xor_tt_held", if1.truth_table, 4'b0000);
    step();
    chk("xor_done_k7", 4'(if1.done), 4'd0);
    step();
    chk("xor_done_k8", 4'(if1.done), 4'd1);
    chk("xor_tt", if1.truth_table, 4'b0110);
    chk("xor_op", 4'(if1.op_code), 4'b0100);
    chk("xor_valid", 4'(if1.valid), 4'd1);
    chk("xor_probe_done", 4'({if1.probe_a, if1.probe_b}), 4'b0000);
    step();
    chk("xor_done_k9", 4'(if1.done), 4'd0);
    chk("xor_busy_k9", 4'(if1.busy), 4'd0);

    // All eight selects, S=0
    for (int s = 0; s < 8; s++) begin
      sel0 = 3'(s);
      if0.start = 1'b1;
      step();
      if0.start = 1'b0;
      stepn(3);
      chk("sel_done_early", 4'(if0.done), 4'd0);
      step();
      chk("sel_done", 4'(if0.done), 4'd1);
      chk("sel_op", 4'(if0.op_code), 4'(s));
      chk("sel_valid", 4'(if0.valid), 4'd1);
      chk("sel_tt", if0.truth_table, exp_tt[s]);
      step();
      chk("sel_done_after", 4'(if0.done), 4'd0);
    end

    // Invalid pattern: probe_out stuck at 1
    tie0 = 1'b1;
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    stepn(4);
    chk("inv_done", 4'(if0.done), 4'd1);
    chk("inv_tt", if0.truth_table, 4'b1111);
    chk("inv_valid", 4'(if0.valid), 4'd0);
    chk("inv_op", 4'(if0.op_code), 4'd0);
    step();
    tie0 = 1'b0;

    // Start while busy, then start held through DONE (S=1, NAND)
    sel1 = 3'b011;
    if1.start = 1'b1;
    step();                                      // edge k
    if1.start = 1'b0;
    stepn(2);
    if1.start = 1'b1;
    step();                                      // edge k+3, ignored
    if1.start = 1'b0;
    chk("bsy_busy", 4'(if1.busy), 4'd1);
    stepn(4);
    chk("bsy_done_k7", 4'(if1.done), 4'd0);
    step();
    chk("bsy_done_k8", 4'(if1.done), 4'd1);
    chk("bsy_op", 4'(if1.op_code), 4'b0011);
    chk("bsy_tt", if1.truth_table, 4'b0111);
    if1.start = 1'b1;
    step();                                      // edge k+9, DONE -> IDLE
    chk("b2b_done_k9", 4'(if1.done), 4'd0);
    chk("b2b_busy_k9", 4'(if1.busy), 4'd0);
    step();                                      // edge k+10, accepted
    if1.start = 1'b0;
    chk("b2b_busy_k10", 4'(if1.busy), 4'd1);
    chk("b2b_probe_k10", 4'({if1.probe_a, if1.probe_b}), 4'b0000);
    chk("b2b_op_held", 4'(if1.op_code), 4'b0011);
    stepn(8);
    chk("b2b_done", 4'(if1.done), 4'd1);
    chk("b2b_op", 4'(if1.op_code), 4'b0011);
    step();

    // Reset mid-run after the second sample (S=1, NOT B)
    sel1 = 3'b001;
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    stepn(4);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_busy", 4'(if1.busy), 4'd0);
    chk("mid_probes", 4'({if1.probe_a, if1.probe_b}), 4'd0);
    chk("mid_tt", if1.truth_table, 4'd0);
    chk("mid_op", 4'(if1.op_code), 4'd0);
    chk("mid_valid", 4'(if1.valid), 4'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mid_no_done", 4'(if1.done), 4'd0);
    end

    // Clean run after reset (S=1, OR)
    sel1 = 3'b110;
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    stepn(8);
    chk("or_done", 4'(if1.done), 4'd1);
    chk("or_tt", if1.truth_table, 4'b1110);
    chk("or_op", 4'(if1.op_code), 4'b0110);
    chk("or_valid", 4'(if1.valid), 4'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
